// File: rtl/event_tick_gen.sv
// -----------------------------------------------------------------------------
// event_tick_gen
//
// Conditions a raw asynchronous event line for the event counter. The line is
// synchronised into the ACLK domain and debounced with a run-time programmable
// qualification length. A single-cycle TICK is emitted on the selected edge of
// the debounced level.
//
// Parameters:
//   SYNC_STAGES     synchroniser depth (>= 2)
//   DEBOUNCE_WIDTH  width of DEBOUNCE_LEN and the qualification counter
//   EDGE_MODE       0 = rising, 1 = falling, 2 = both edges produce a TICK
//
// Ports:
//   ACLK          in   clock, rising edge
//   ARESET        in   synchronous active-high reset
//   ENABLE        in   tick enable (debouncing runs regardless)
//   EVENT_IN      in   raw event line, asynchronous to ACLK
//   DEBOUNCE_LEN  in   stable cycles required to qualify a change (0 acts as 1)
//   LEVEL         out  debounced level, registered
//   TICK          out  one-cycle qualified-edge pulse, registered
//   GLITCH_COUNT  out  8-bit saturating count of rejected transitions
//                      (present only when EVENT_TICK_GEN_GLITCH_CNT_EN is defined)
//
// Optional feature macro: EVENT_TICK_GEN_GLITCH_CNT_EN
//
// State table:
//   state     | meaning
//   ST_STABLE | synchronised input equals LEVEL; counter held at 0
//   ST_QUAL   | synchronised input differs from LEVEL; qualifying a transition
// -----------------------------------------------------------------------------
module event_tick_gen #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_WIDTH = 8,
    parameter int EDGE_MODE      = 0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      ENABLE,
    input  logic                      EVENT_IN,
    input  logic [DEBOUNCE_WIDTH-1:0] DEBOUNCE_LEN,
    output logic                      LEVEL,
    output logic                      TICK
`ifdef EVENT_TICK_GEN_GLITCH_CNT_EN
    ,
    output logic [7:0]                GLITCH_COUNT
`endif
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } state_t;

    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ONE = DEBOUNCE_WIDTH'(1);
    localparam bit TICK_ON_RISE = (EDGE_MODE == 0) || (EDGE_MODE == 2);
    localparam bit TICK_ON_FALL = (EDGE_MODE == 1) || (EDGE_MODE == 2);

    state_t                      state_q, state_d;
    logic [SYNC_STAGES-1:0]      sync_q,  sync_d;
    logic                        level_q, level_d;
    logic                        tick_q,  tick_d;
    logic [DEBOUNCE_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [DEBOUNCE_WIDTH-1:0]   len_q,   len_d;

    logic                        sync_s;
    logic [DEBOUNCE_WIDTH-1:0]   len_eff;
    logic [DEBOUNCE_WIDTH-1:0]   cnt_inc;
    logic                        flip;
    logic                        edge_ok;

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign len_eff = (DEBOUNCE_LEN == '0) ? CNT_ONE : DEBOUNCE_LEN;
    // cnt_q holds the differing cycles already seen; cnt_inc includes this one.
    // cnt_q < len_q while qualifying, so cnt_inc never wraps.
    assign cnt_inc = cnt_q + CNT_ONE;
    assign edge_ok = level_q ? TICK_ON_FALL : TICK_ON_RISE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        level_d = level_q;
        flip    = 1'b0;
        sync_d  = {sync_q[SYNC_STAGES-2:0], EVENT_IN};

        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync_s != level_q) begin
                    // Length is latched only here; later DEBOUNCE_LEN changes
                    // wait for the next qualification.
                    len_d = len_eff;
                    if (len_eff == CNT_ONE) begin
                        flip = 1'b1;
                    end else begin
                        state_d = ST_QUAL;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_QUAL: begin
                if (sync_s != level_q) begin
                    if (cnt_inc == len_q) begin
                        flip = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase

        if (flip) begin
            level_d = ~level_q;
            state_d = ST_STABLE;
            cnt_d   = '0;
        end

        // Suppressed ticks are dropped, not deferred.
        tick_d = flip & ENABLE & edge_ok;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_STABLE;
            sync_q  <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign LEVEL = level_q;
    assign TICK  = tick_q;

`ifdef EVENT_TICK_GEN_GLITCH_CNT_EN
    logic [7:0] glitch_cnt_q, glitch_cnt_d;
    logic       glitch;

    // A glitch is a QUAL cycle where the input has fallen back to LEVEL.
    assign glitch = (state_q == ST_QUAL) && (sync_s == level_q);

    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            glitch_cnt_q <= 8'd0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign GLITCH_COUNT = glitch_cnt_q;
`endif

endmodule
